// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer:
// FSM state codes, default register-address width, NOP encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int HZ_REG_AW = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef logic [1:0] hz_state_t;

    localparam hz_state_t ST_RUN      = 2'd0;
    localparam hz_state_t ST_MEM_WAIT = 2'd1;
    localparam hz_state_t ST_REDIRECT = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bundle between pipeline (master) and hazard sequencer (slave).
// Master drives hazard sources; slave drives stall/flush/PC-enable.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
);

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_redirect;
    logic              dmem_busy;
    logic              imem_valid;

    logic              pc_write;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_stall;
    logic              id_ex_flush;
    logic              ex_mem_stall;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_redirect,
        output dmem_busy, imem_valid,
        input  pc_write, if_id_stall, if_id_flush,
        input  id_ex_stall, id_ex_flush, ex_mem_stall
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_redirect,
        input  dmem_busy, imem_valid,
        output pc_write, if_id_stall, if_id_flush,
        output id_ex_stall, id_ex_flush, ex_mem_stall
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating performance counter with enable.
// Ports: clk, reset (async, active-low), en, cnt[W-1:0].
module hazard_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe plus perf counters and watchdog.
// Ports: clk, reset (async, active-low), hz (slave), stall_cnt, flush_cnt, timeout_err.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW        = HZ_REG_AW,
    parameter int REDIR_BUBBLES = 2,
    parameter int CNT_W         = 16,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int BUB_W  = 3;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [BUB_W-1:0]  BUB_LOAD  = BUB_W'(REDIR_BUBBLES - 1);

    hz_state_t         state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [BUB_W-1:0]  bub_q;
    logic              pend_q;

    logic [REG_AW-1:0] ex_rd;
    logic              frozen;
    logic              redir;
    logic              load_use;

    logic pc_write_c;
    logic if_id_stall_c;
    logic if_id_flush_c;
    logic id_ex_stall_c;
    logic id_ex_flush_c;
    logic ex_mem_stall_c;

    assign ex_rd  = hz.ex_rd;
    assign frozen = hz.dmem_busy;
    // A redirect deferred by a memory freeze fires on the first free cycle.
    assign redir  = !frozen && (hz.ex_redirect || pend_q);

    assign load_use = hz.ex_mem_read && (ex_rd != '0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == ex_rd)));

    always_comb begin
        pc_write_c     = 1'b1;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if (!reset) begin
            pc_write_c    = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (frozen) begin
            pc_write_c     = 1'b0;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
        end else if (redir) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (state_q == ST_REDIRECT) begin
            // Squash wrong-path fetches still in the imem pipe.
            if_id_flush_c = 1'b1;
        end else if (load_use) begin
            pc_write_c    = 1'b0;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (!hz.imem_valid) begin
            pc_write_c    = 1'b0;
            if_id_flush_c = 1'b1;
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_stall  = id_ex_stall_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_stall = ex_mem_stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            bub_q       <= '0;
            pend_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else if (frozen) begin
            state_q <= ST_MEM_WAIT;
            bub_q   <= '0;
            if (hz.ex_redirect) begin
                pend_q <= 1'b1;
            end
            if (wait_q != WAIT_MAX) begin
                wait_q <= wait_q + 1'b1;
            end
            if (wait_q >= WAIT_LAST) begin
                timeout_err <= 1'b1;
            end
        end else begin
            wait_q <= '0;
            pend_q <= 1'b0;
            if (redir) begin
                if (REDIR_BUBBLES > 1) begin
                    state_q <= ST_REDIRECT;
                    bub_q   <= BUB_LOAD;
                end else begin
                    state_q <= ST_RUN;
                end
            end else if (state_q == ST_REDIRECT) begin
                bub_q <= bub_q - 1'b1;
                if (bub_q == BUB_W'(1)) begin
                    state_q <= ST_RUN;
                end
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

    hazard_perf_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (!pc_write_c),
        .cnt  (stall_cnt)
    );

    hazard_perf_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (redir),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int BUB  = 2;
    localparam int CW   = 4;
    localparam int TO   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(AW)) hz ();

    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          timeout_err;

    pipeline_hazard_ctrl #(
        .REG_AW       (AW),
        .REDIR_BUBBLES(BUB),
        .CNT_W        (CW),
        .MEM_TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hz         (hz),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: wrong-path bubbles left, freeze length, deferred redirect.
    int m_bub;
    int m_wait;
    int m_stall;
    int m_flush;
    bit m_pend;
    bit m_to;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bub   = 0;
        m_wait  = 0;
        m_stall = 0;
        m_flush = 0;
        m_pend  = 0;
        m_to    = 0;
    endtask

    // {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
    function automatic logic [5:0] exp_ctrl();
        bit lu;
        lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
              (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        if (!reset)                      return 6'b001010;
        if (hz.dmem_busy)                return 6'b010101;
        if (hz.ex_redirect || m_pend)    return 6'b101010;
        if (m_bub > 0)                   return 6'b101000;
        if (lu)                          return 6'b010010;
        if (!hz.imem_valid)              return 6'b001000;
        return 6'b100000;
    endfunction

    task automatic model_clock(logic [5:0] e);
        if (hz.dmem_busy) begin
            m_wait = (m_wait < TO) ? m_wait + 1 : TO;
            if (m_wait >= TO) m_to = 1;
            if (hz.ex_redirect) m_pend = 1;
            m_bub = 0;
        end else begin
            m_wait = 0;
            if (hz.ex_redirect || m_pend) begin
                if (m_flush < CMAX) m_flush++;
                m_pend = 0;
                m_bub  = BUB - 1;
            end else if (m_bub > 0) begin
                m_bub--;
            end
        end
        if (!e[5] && m_stall < CMAX) m_stall++;
    endtask

    task automatic step();
        logic [5:0] e;
        @(negedge clk);
        if (!reset) model_reset();
        e = exp_ctrl();
        check("ctrl", {26'd0, hz.pc_write, hz.if_id_stall, hz.if_id_flush,
                       hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall}, {26'd0, e});
        check("stall_cnt", {28'd0, stall_cnt}, m_stall);
        check("flush_cnt", {28'd0, flush_cnt}, m_flush);
        check("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
        @(posedge clk);
        if (reset) model_clock(e);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1      = '0;
        hz.id_rs2      = '0;
        hz.id_use_rs1  = 1'b0;
        hz.id_use_rs2  = 1'b0;
        hz.ex_rd       = '0;
        hz.ex_mem_read = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.dmem_busy   = 1'b0;
        hz.imem_valid  = 1'b1;
    endtask

    initial begin
        int f0;
        int busy_left;
        model_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // load-use: exactly one bubble
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_rs1      = 5'd5;
        hz.id_use_rs1  = 1'b1;
        step();
        idle();
        step();
        check("t1_stall_cnt", {28'd0, stall_cnt}, 32'd1);

        // redirect pulse
        hz.ex_redirect = 1'b1;
        step();
        idle();
        step();
        step();
        check("t2_flush_cnt", {28'd0, flush_cnt}, 32'd1);

        // redirect deferred under a 4-cycle freeze
        f0 = int'(flush_cnt);
        hz.dmem_busy   = 1'b1;
        hz.ex_redirect = 1'b1;
        step();
        hz.ex_redirect = 1'b0;
        repeat (3) step();
        hz.dmem_busy = 1'b0;
        step();
        check("t3_flush_cnt", {28'd0, flush_cnt}, f0 + 1);
        step();
        step();

        // watchdog
        hz.dmem_busy = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 7) check("t4_to_early", {31'd0, timeout_err}, 32'd0);
            if (i == 8) check("t4_to_set", {31'd0, timeout_err}, 32'd1);
        end
        hz.dmem_busy = 1'b0;
        step();
        check("t4_to_sticky", {31'd0, timeout_err}, 32'd1);

        // load-use on x0, then load-use colliding with redirect
        hz.ex_mem_read = 1'b1;
        hz.ex_rd       = '0;
        hz.id_rs1      = '0;
        hz.id_use_rs1  = 1'b1;
        step();
        hz.ex_rd       = 5'd3;
        hz.id_rs2      = 5'd3;
        hz.id_use_rs2  = 1'b1;
        hz.ex_redirect = 1'b1;
        step();
        idle();
        step();
        step();

        // reset in the middle of the redirect bubble
        hz.ex_redirect = 1'b1;
        step();
        idle();
        reset = 1'b0;
        step();
        check("t6_stall_rst", {28'd0, stall_cnt}, 32'd0);
        step();
        reset = 1'b1;
        step();
        step();

        // random traffic
        busy_left = 0;
        for (int c = 0; c < 800; c++) begin
            if (busy_left > 0) begin
                hz.dmem_busy = 1'b1;
                busy_left--;
            end else if ($urandom % 16 == 0) begin
                hz.dmem_busy = 1'b1;
                busy_left = $urandom_range(0, 11);
            end else begin
                hz.dmem_busy = 1'b0;
            end
            hz.ex_redirect = ($urandom % 8 == 0);
            hz.ex_mem_read = ($urandom % 3 == 0);
            hz.ex_rd       = AW'($urandom_range(0, 3));
            hz.id_rs1      = AW'($urandom_range(0, 3));
            hz.id_rs2      = AW'($urandom_range(0, 3));
            hz.id_use_rs1  = $urandom % 2 == 0;
            hz.id_use_rs2  = $urandom % 2 == 0;
            hz.imem_valid  = ($urandom % 8 != 0);
            reset          = ($urandom % 150 != 0);
            step();
        end
        reset = 1'b1;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
